// File: rtl/adc_capture.sv
`timescale 1ns/1ps
// Parallel ADC capture engine: power-up sequencing, sample clock divider,
// burst capture with format conversion, and a first-word-fall-through FIFO.
module adc_capture #(
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned DIV         = 2,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned WAKE_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CNT_WIDTH-1:0]         burst_len,
    input  logic                         format,
    output logic                         adc_clk,
    output logic                         adc_pwrdn,
    input  logic [0:DATA_WIDTH-1]        adc_data,
    input  logic                         rd_en,
    output logic [0:DATA_WIDTH-1]        rd_data,
    output logic                         fifo_empty,
    output logic                         fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned DCW = $clog2(2 * DIV);
    localparam int unsigned WCW = $clog2(WAKE_CYCLES + 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(2 * DIV - 1);
    localparam logic [DCW-1:0] DIV_HALF = DCW'(DIV);

    typedef enum logic [1:0] {ST_IDLE, ST_WAKE, ST_RUN, ST_DONE} state_t;

    state_t                 state, state_next;
    logic [WCW-1:0]         wake_cnt;
    logic [DCW-1:0]         div_cnt, div_next;
    logic [CNT_WIDTH-1:0]   len_q, cap_cnt, cap_inc;
    logic                   fmt_q, load, capture, wr_pend;
    logic [0:DATA_WIDTH-1]  sample_q, conv;
    logic [0:DATA_WIDTH-1]  mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic                   wr_ok, rd_ok;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        cap_inc    = cap_cnt + CNT_WIDTH'(1);
        div_next   = '0;
        conv       = adc_data;
        conv[0]    = adc_data[0] ^ fmt_q;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_WAKE;
                    load       = 1'b1;
                end
            end
            ST_WAKE: begin
                if (abort)
                    state_next = ST_IDLE;
                else if (wake_cnt == '0)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DCW'(1);
                    if (div_cnt == DIV_LAST) begin
                        capture = 1'b1;
                        if (len_q != '0 && cap_inc == len_q)
                            state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_WAKE) || (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign adc_pwrdn = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wake_cnt <= '0;
            div_cnt  <= '0;
            adc_clk  <= 1'b0;
            len_q    <= '0;
            fmt_q    <= 1'b0;
            cap_cnt  <= '0;
            sample_q <= '0;
            wr_pend  <= 1'b0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            // adc_clk is registered so it lines up with the divider count it reflects
            adc_clk <= (state_next == ST_RUN) && (div_next < DIV_HALF);
            wr_pend <= capture;
            if (load) begin
                wake_cnt <= WCW'(WAKE_CYCLES - 1);
                len_q    <= burst_len;
                fmt_q    <= format;
                cap_cnt  <= '0;
            end else if (state == ST_WAKE && wake_cnt != '0) begin
                wake_cnt <= wake_cnt - WCW'(1);
            end
            if (capture) begin
                sample_q <= conv;
                cap_cnt  <= cap_inc;
            end
        end
    end

    // A full FIFO still accepts a write when the same cycle pops the head
    assign wr_ok = wr_pend && (!fifo_full || rd_en);
    assign rd_ok = rd_en && !fifo_empty;

    always_comb begin
        fifo_level = wr_ptr - rd_ptr;
        fifo_empty = (fifo_level == '0);
        fifo_full  = (fifo_level == (AW + 1)'(FIFO_DEPTH));
        rd_data    = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr[AW-1:0]] <= sample_q;
                wr_ptr              <= wr_ptr + (AW + 1)'(1);
            end
            if (rd_ok)
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            if (load)
                overflow <= 1'b0;
            else if (wr_pend && fifo_full && !rd_en)
                overflow <= 1'b1;
        end
    end

endmodule

// File: doc/adc_capture.md
# adc_capture

Capture engine for the ADDA board's parallel ADC, the receive counterpart of the PLB DAC output path. It powers up the converter, generates the ADC sample clock from the system clock, and captures bursts of 10-bit samples. Each sample is converted to the selected number format and buffered in a first-word-fall-through FIFO. The PLB slave logic drains the FIFO under MicroBlaze software control.

## Interface
- DATA_WIDTH, 10, ADC sample width.
- DIV, 2, clk cycles per half period of adc_clk (≥1).
- FIFO_DEPTH, 16, FIFO entries (power of 2, ≥2).
- CNT_WIDTH, 16, burst counter width.
- WAKE_CYCLES, 8, clk cycles between power-up and first adc_clk edge (≥1).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a burst when idle.
- abort  in  1  single-cycle pulse; ends a burst immediately.
- burst_len  in  CNT_WIDTH  number of samples; 0 means continuous capture until abort. Sampled at start.
- format  in  1  0 selects offset binary (pass-through); 1 selects two's complement (MSB inverted). Sampled at start.
- adc_clk  out  1  ADC conversion clock.
- adc_pwrdn  out  1  ADC power-down, high when idle.
- adc_data  in  [0:DATA_WIDTH-1]  ADC output bus; bit 0 is the MSB.
- rd_en  in  1  pops the FIFO head.
- rd_data  out  [0:DATA_WIDTH-1]  FIFO head; valid while fifo_empty=0.
- fifo_empty  out  1  FIFO empty.
- fifo_full  out  1  FIFO full.
- fifo_level  out  log2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky flag; set when a sample is dropped.
- busy  out  1  high in WAKE and RUN.
- done  out  1  single-cycle pulse when a finite burst completes.

## Operation
- **Reset values:** adc_clk=0, adc_pwrdn=1, busy=0, done=0, overflow=0, fifo_empty=1, fifo_full=0, fifo_level=0, rd_data=0. FIFO pointers are cleared and the FSM is in IDLE.
- **FSM states:**
  - IDLE: adc_pwrdn=1, adc_clk=0.
  - IDLE → WAKE on start. This latches burst_len and format, clears overflow, and loads the wake counter.
  - WAKE: adc_pwrdn=0, adc_clk=0. Moves to RUN after WAKE_CYCLES cycles.
  - RUN: runs the divider and captures samples.
  - RUN → DONE when the capture count equals a nonzero burst_len.
  - DONE: lasts 1 cycle, done=1, then → IDLE.
- **Start handling:** start is ignored in WAKE, RUN and DONE.
- **Abort:** abort in WAKE or RUN → IDLE on the next edge. No done pulse is issued and FIFO contents are retained. Abort in IDLE has no effect.
- **Simultaneous start and abort in IDLE:** start wins.
- **Divider:**
  - cnt runs 0..2*DIV-1 and wraps.
  - adc_clk=1 for cnt<DIV, 0 otherwise. It is registered; cnt=0 on entry to RUN.
- **Capture:** on the edge ending a cycle with cnt=2*DIV-1, adc_data is registered and the capture counter increments. On the following edge, the converted word is written to the FIFO.
- **Conversion:** format=1 inverts bit 0 only. No other arithmetic is applied.
- **Full FIFO:** a write while full and rd_en=0 drops the sample and sets overflow. A write while full with rd_en=1 the same cycle is accepted and the level is unchanged.
- **Read side:** rd_en while empty is ignored. A simultaneous read and write on an empty FIFO performs the write only.
- **Pointer wrap:** pointers wrap modulo FIFO_DEPTH and are compared with an extra wrap bit.
- **Last sample:** the final sample of a burst is written in the DONE cycle; done and that write occur together.

## Timing
- **Sample period:** 2*DIV clk cycles. A sample is captured every period while in RUN.
- **Start to RUN:** start at edge S puts the block in WAKE from S+1 and in RUN from S+1+WAKE_CYCLES.
- **First capture (DIV=2):** with RUN entered at edge R, the first capture is at R+4 and its FIFO write at R+5. fifo_empty drops after R+5.
- **Capture-to-read latency:** 1 clk edge from capture to FIFO write. rd_data updates on the edge after a write to an empty FIFO, or after a pop.
- **done:** asserted for exactly 1 cycle, burst_len*2*DIV cycles after RUN entry.
- **Reset mid-operation:** the block returns to reset values immediately and asynchronously, and FIFO data is lost.

## Test plan
- **Reset:** hold rst=0 for 5 cycles, then release → all outputs at reset values, adc_pwrdn=1, adc_clk static 0.
- **Short burst:** DIV=2, burst_len=4, format=0, adc_data stepping 0x001..0x004 per period → adc_clk period 4, fifo_level=4, reads return 0x001..0x004, and done fires once, 16 cycles after RUN entry.
- **Two's complement:** format=1, adc_data=0x200 then 0x1FF → reads return 0x000 then 0x3FF.
- **Overflow:** FIFO_DEPTH=16, burst_len=20, no reads → fifo_full=1, level=16, overflow=1, and reads return the first 16 samples in order. The next start clears overflow.
- **Continuous capture with abort:** burst_len=0, reader popping every cycle, abort after 10 captures → exactly 10 samples read, no done pulse, and adc_pwrdn=1 the cycle after abort.
- **Edge cases:**
  - start pulse during RUN → ignored, and the burst count is unchanged.
  - rd_en on an empty FIFO → level stays 0.
  - rst=0 mid-RUN → immediate reset values.
